// File: rtl/umult_arbiter.sv
// Two-requester round-robin front end for a shared 8x8 unsigned multiplier.
// Serves one request at a time and returns the product (or a timeout error) with a one-cycle ack.
module umult_arbiter #(
   parameter int unsigned TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        _reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [7:0]  a0,
   input  logic [7:0]  b0,
   input  logic [7:0]  a1,
   input  logic [7:0]  b1,
   output logic        ack0,
   output logic        ack1,
   output logic        err,
   output logic [15:0] result,
   output logic        gnt,
   output logic        busy,
   output logic        mul_start,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   input  logic [15:0] mul_result,
   input  logic        mul_done
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;

   logic             pointer;
   logic             pointer_d;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_d;
   logic             timeout_hit;
   logic             pick;

   logic             ack0_d;
   logic             ack1_d;
   logic             err_d;
   logic [15:0]      result_d;
   logic             gnt_d;
   logic             busy_d;
   logic             mul_start_d;
   logic [7:0]       mul_a_d;
   logic [7:0]       mul_b_d;

   // The last WAIT cycle is the one in which the counter already holds TIMEOUT-1.
   assign timeout_hit = (count == CNT_LAST);

   // On a tie, serve the requester that was not served last.
   assign pick = (req0 && req1) ? ~pointer : req1;

   // State register
   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (req0 || req1) next_state = S_LAUNCH;
         S_LAUNCH: next_state = S_WAIT;
         S_WAIT:   if (mul_done || timeout_hit) next_state = S_RESP;
         S_RESP:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Next values for the registered outputs, counter and round-robin pointer
   always_comb begin
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      mul_start_d = 1'b0;
      busy_d      = (next_state != S_IDLE);
      err_d       = err;
      result_d    = result;
      gnt_d       = gnt;
      mul_a_d     = mul_a;
      mul_b_d     = mul_b;
      count_d     = count;
      pointer_d   = pointer;
      case (state)
         S_IDLE: begin
            if (req0 || req1) begin
               gnt_d       = pick;
               mul_a_d     = pick ? a1 : a0;
               mul_b_d     = pick ? b1 : b0;
               mul_start_d = 1'b1;
            end
         end
         S_LAUNCH: begin
            count_d = '0;
         end
         S_WAIT: begin
            // A completion arriving on the timeout cycle still delivers its product.
            if (mul_done) begin
               result_d = mul_result;
               err_d    = 1'b0;
               ack0_d   = ~gnt;
               ack1_d   = gnt;
            end else if (timeout_hit) begin
               result_d = 16'h0000;
               err_d    = 1'b1;
               ack0_d   = ~gnt;
               ack1_d   = gnt;
            end else begin
               count_d = count + CNT_W'(1);
            end
         end
         S_RESP: begin
            pointer_d = gnt;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         err       <= 1'b0;
         result    <= 16'h0000;
         gnt       <= 1'b0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_a     <= 8'h00;
         mul_b     <= 8'h00;
         count     <= '0;
         pointer   <= 1'b1;
      end else begin
         ack0      <= ack0_d;
         ack1      <= ack1_d;
         err       <= err_d;
         result    <= result_d;
         gnt       <= gnt_d;
         busy      <= busy_d;
         mul_start <= mul_start_d;
         mul_a     <= mul_a_d;
         mul_b     <= mul_b_d;
         count     <= count_d;
         pointer   <= pointer_d;
      end
   end

endmodule

// File: tb/tb_umult_arbiter.sv
// Scoreboard bench for umult_arbiter with a behavioural multiplier of programmable latency.
module tb_umult_arbiter;

   localparam int unsigned TO = 40;

   typedef struct packed {
      logic        id;
      logic [15:0] res;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        _reset = 1'b0;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [7:0]  a0 = 8'h00;
   logic [7:0]  b0 = 8'h00;
   logic [7:0]  a1 = 8'h00;
   logic [7:0]  b1 = 8'h00;
   logic        ack0;
   logic        ack1;
   logic        err;
   logic [15:0] result;
   logic        gnt;
   logic        busy;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_result = 16'h0000;
   logic        mul_done;

   logic        md_q = 1'b0;
   logic        poke = 1'b0;
   logic        done_en = 1'b1;
   logic        pend = 1'b0;
   logic [15:0] prod = 16'h0000;
   int          lat = 1;
   int          rem = 0;

   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   int          acks = 0;
   int          starts = 0;
   int          ack_cyc = 0;
   int          last_start = 0;
   int          prev_start = 0;
   exp_t        sb[$];

   assign mul_done = md_q | poke;

   umult_arbiter #(.TIMEOUT(TO)) dut (
      .clock(clock), ._reset(_reset),
      .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .err(err), .result(result), .gnt(gnt), .busy(busy),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .mul_done(mul_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Multiplier: done pulses 'lat' cycles after the start strobe is sampled
   always @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         pend <= 1'b0;
         md_q <= 1'b0;
         rem  <= 0;
      end else begin
         md_q <= 1'b0;
         if (mul_start) begin
            pend <= 1'b1;
            rem  <= lat;
            prod <= 16'(mul_a) * 16'(mul_b);
         end else if (pend) begin
            if (rem <= 1) begin
               md_q       <= done_en;
               mul_result <= prod;
               pend       <= 1'b0;
            end else begin
               rem <= rem - 1;
            end
         end
      end
   end

   // Monitor: pop the scoreboard on every ack and track start strobes
   always @(negedge clock) begin
      exp_t e;
      if (_reset) begin
         if (mul_start) begin
            starts     <= starts + 1;
            prev_start <= last_start;
            last_start <= cyc;
         end
         if (ack0 || ack1) begin
            acks    <= acks + 1;
            ack_cyc <= cyc;
            checks++;
            if (ack0 && ack1) $display("FAIL double_ack: ack0=%b ack1=%b, want one-hot", ack0, ack1);
            else passed++;
            checks++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_ack: ack0=%b ack1=%b result=%h with empty scoreboard", ack0, ack1, result);
            end else begin
               e = sb.pop_front();
               if (ack1 !== e.id || result !== e.res || err !== e.err)
                  $display("FAIL ack_payload: got id=%b result=%h err=%b, want id=%b result=%h err=%b",
                           ack1, result, err, e.id, e.res, e.err);
               else passed++;
            end
         end
      end
   end

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) $display("FAIL reset_ack: got %b%b want 00", ack0, ack1); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", gnt); else passed++;
      checks++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b want 0", mul_start); else passed++;
      checks++; if (result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result); else passed++;
      checks++; if (mul_a !== 8'h00 || mul_b !== 8'h00) $display("FAIL reset_operands: got %h %h want 00 00", mul_a, mul_b); else passed++;
      @(posedge clock); #1 _reset = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
      checks++; if (busy !== 1'b0) $display("FAIL idle_after_reset_busy: got %b want 0", busy); else passed++;
   endtask

   task automatic test_single();
      exp_t e;
      int   ab = acks;
      int   sbase = starts;
      lat = 1; done_en = 1'b1;
      a0 = 8'h0C; b0 = 8'h0A;
      e.id = 1'b0; e.res = 16'h0078; e.err = 1'b0; sb.push_back(e);
      req0 = 1'b1;
      for (int i = 0; i < 50 && acks < ab + 1; i++) begin @(posedge clock); #1; end
      req0 = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      checks++; if (acks != ab + 1) $display("FAIL single_ack_count: got %0d want %0d", acks - ab, 1); else passed++;
      checks++; if (starts != sbase + 1) $display("FAIL single_start_count: got %0d want %0d", starts - sbase, 1); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL single_idle: busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_tie();
      exp_t e;
      int   ab;
      _reset = 1'b0;
      @(posedge clock); #1 _reset = 1'b1;
      @(posedge clock); #1;
      ab = acks;
      lat = 1; done_en = 1'b1;
      a0 = 8'h03; b0 = 8'h7F; a1 = 8'hFF; b1 = 8'hFF;
      e.id = 1'b0; e.res = 16'h017D; e.err = 1'b0; sb.push_back(e);
      e.id = 1'b1; e.res = 16'hFE01; e.err = 1'b0; sb.push_back(e);
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 50 && acks < ab + 1; i++) begin @(posedge clock); #1; end
      req0 = 1'b0;
      for (int i = 0; i < 50 && acks < ab + 2; i++) begin @(posedge clock); #1; end
      req1 = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      checks++; if (acks != ab + 2) $display("FAIL tie_ack_count: got %0d want %0d", acks - ab, 2); else passed++;
      // LAUNCH + two WAIT + RESP + one IDLE between the start strobes
      checks++; if (last_start - prev_start != lat + 4)
         $display("FAIL tie_grant_spacing: got %0d cycles want %0d", last_start - prev_start, lat + 4); else passed++;
   endtask

   task automatic test_alternate();
      exp_t e;
      int   ab = acks;
      int   sbase = starts;
      lat = 3; done_en = 1'b1;
      a0 = 8'h21; b0 = 8'h09; a1 = 8'hC8; b1 = 8'h02;
      for (int k = 0; k < 4; k++) begin
         e.id  = k[0];
         e.res = k[0] ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
         e.err = 1'b0;
         sb.push_back(e);
      end
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 200 && acks < ab + 4; i++) begin @(posedge clock); #1; end
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      checks++; if (acks != ab + 4) $display("FAIL alternate_ack_count: got %0d want %0d", acks - ab, 4); else passed++;
      checks++; if (starts != sbase + 4) $display("FAIL alternate_start_count: got %0d want %0d", starts - sbase, 4); else passed++;
   endtask

   task automatic test_timeout();
      exp_t e;
      int   ab = acks;
      lat = 1; done_en = 1'b0;
      a0 = 8'h05; b0 = 8'h06;
      e.id = 1'b0; e.res = 16'h0000; e.err = 1'b1; sb.push_back(e);
      req0 = 1'b1;
      for (int i = 0; i < TO + 30 && acks < ab + 1; i++) begin @(posedge clock); #1; end
      req0 = 1'b0;
      @(posedge clock); #1;
      checks++; if (acks != ab + 1) $display("FAIL timeout_ack_count: got %0d want %0d", acks - ab, 1); else passed++;
      // WAIT begins the cycle after the start strobe; ack follows TO cycles later
      checks++; if (ack_cyc - last_start != int'(TO) + 1)
         $display("FAIL timeout_latency: got %0d want %0d", ack_cyc - last_start, TO + 1); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL timeout_idle: busy=%b want 0", busy); else passed++;
      done_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   ab = acks;
      int   sbase;
      lat = 2; done_en = 1'b0;
      a1 = 8'h11; b1 = 8'h0F;
      req1 = 1'b1;
      repeat (6) begin @(posedge clock); #1; end
      checks++; if (busy !== 1'b1 || gnt !== 1'b1) $display("FAIL midreset_pre: busy=%b gnt=%b want 1 1", busy, gnt); else passed++;
      #2 _reset = 1'b0;
      #1;
      checks++;
      if ({ack0, ack1, err, busy, gnt, mul_start, result, mul_a, mul_b} !== 36'd0)
         $display("FAIL midreset_async: got ack=%b%b err=%b busy=%b gnt=%b start=%b result=%h a=%h b=%h want all 0",
                  ack0, ack1, err, busy, gnt, mul_start, result, mul_a, mul_b);
      else passed++;
      done_en = 1'b1;
      e.id = 1'b1; e.res = 16'h00FF; e.err = 1'b0; sb.push_back(e);
      @(posedge clock); #1 _reset = 1'b1;
      sbase = starts;
      for (int i = 0; i < 50 && acks < ab + 1; i++) begin @(posedge clock); #1; end
      req1 = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      checks++; if (acks != ab + 1) $display("FAIL midreset_ack_count: got %0d want %0d", acks - ab, 1); else passed++;
      checks++; if (starts != sbase + 1) $display("FAIL midreset_start_count: got %0d want %0d", starts - sbase, 1); else passed++;
   endtask

   task automatic test_idle_done();
      int ab = acks;
      int sbase = starts;
      repeat (2) begin @(posedge clock); #1; end
      poke = 1'b1;
      @(posedge clock); #1 poke = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      checks++; if (busy !== 1'b0) $display("FAIL idle_done_busy: got %b want 0", busy); else passed++;
      checks++; if (acks != ab) $display("FAIL idle_done_ack: got %0d acks want 0", acks - ab); else passed++;
      checks++; if (starts != sbase) $display("FAIL idle_done_start: got %0d starts want 0", starts - sbase); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_alternate();
      test_timeout();
      test_reset_mid();
      test_idle_done();
      checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/umult_arbiter.md
UMULT_ARBITER -- requirements
Module: umult_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 40, WAIT-state cycle limit before mul_done is declared missing.
REQ-002 SHALL have port: clock  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: _reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req0 / req1  input  1 each  level requests from requester 0 / 1.
REQ-005 SHALL have port: a0, b0 / a1, b1  input  8 each  unsigned operands of requester 0 / 1, stable while that req is high.
REQ-006 SHALL have port: ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-007 SHALL have port: err  output  1  qualifies the ack pulse; 1 means timeout, result invalid.
REQ-008 SHALL have port: result  output  16  product of the granted transaction; held until the next capture.
REQ-009 SHALL have port: gnt  output  1  index of the requester currently or last served.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port: mul_start  output  1  start strobe to the shared 8x8 unsigned multiplier.
REQ-012 SHALL have port: mul_a, mul_b  output  8 each  multiplier operands.
REQ-013 SHALL have port: mul_result  input  16  multiplier product.
REQ-014 SHALL have port: mul_done  input  1  multiplier completion, possibly a Mealy single-cycle pulse.

Function
REQ-015 SHALL implement a 4-state FSM: IDLE, LAUNCH, WAIT, RESP; all outputs SHALL be registered.
REQ-016 IDLE: with no req high, SHALL remain in IDLE.
REQ-017 IDLE: with exactly one req high, SHALL grant that requester.
REQ-018 IDLE: with both req high, SHALL grant the requester not served last (round-robin pointer).
REQ-019 On a grant, SHALL latch that requester's operands into mul_a/mul_b, set gnt, and go to LAUNCH.
REQ-020 LAUNCH: SHALL assert mul_start for exactly this one cycle, clear the timeout counter, then go to WAIT.
REQ-021 WAIT: mul_start=0; the counter SHALL increment each cycle.
REQ-022 WAIT: on mul_done sampled 1, SHALL capture mul_result into result, set err=0, and go to RESP.
REQ-023 WAIT: on counter reaching TIMEOUT with mul_done still 0, SHALL set result=16'h0000 and err=1, then go to RESP.
REQ-024 WAIT: if mul_done and timeout occur in the same cycle, mul_done SHALL win.
REQ-025 RESP: SHALL assert ack[gnt] for exactly one cycle with err valid, update the round-robin pointer to gnt, then go to IDLE.
REQ-026 The requester SHALL drop req at the edge where it samples ack=1; a req still high in IDLE counts as a new request.
REQ-027 Request changes during LAUNCH/WAIT/RESP SHALL be ignored; a non-granted req SHALL stay pending without loss.
REQ-028 Minimum turnaround, first req sampled high to ack, SHALL be 3 + multiplier latency cycles; back-to-back grants SHALL have one IDLE cycle between them.
REQ-029 mul_done in IDLE/LAUNCH/RESP SHALL be ignored.

Reset
REQ-030 _reset low SHALL asynchronously force state=IDLE, pointer=1 (so requester 0 wins the first tie), and counter=0.
REQ-031 _reset low SHALL asynchronously force ack0=ack1=err=mul_start=busy=gnt=0, result=0, and mul_a=mul_b=0.
REQ-032 Reset mid-transaction SHALL abort with no ack issued; a req still high after release SHALL be re-arbitrated from IDLE.

Verification
REQ-033 req0 alone, a0=8'h0C, b0=8'h0A -> one mul_start pulse; ack0 pulse with result=16'h0078, err=0; ack1 never asserted.
REQ-034 req0 and req1 raised in the same cycle after reset (a0=8'h03,b0=8'h7F; a1=8'hFF,b1=8'hFF) -> requester 0 served first (result 16'h017D), then requester 1 (result 16'hFE01); exactly one IDLE cycle between the two grants.
REQ-035 Both reqs held continuously for 4 transactions -> grants alternate 0,1,0,1 and there is never a double ack.
REQ-036 mul_done tied 0 -> ack pulse with err=1 and result=16'h0000 exactly TIMEOUT cycles after WAIT is entered, then back to IDLE.
REQ-037 _reset pulsed low during WAIT -> all outputs 0 immediately; after release with req1 still high, requester 1 is granted and completes normally.
REQ-038 mul_done pulsed in IDLE with no req high -> no state change and no ack.
